// File: rtl/interrupt_controller_if.sv
// Bus and CPU interrupt handshake bundle for interrupt_controller.
// The CPU request line is named intr because "int" is a SystemVerilog keyword.
interface interrupt_controller_if;
   logic        en;
   logic        we;
   logic [31:0] addr;
   logic [31:0] din;
   logic [31:0] dout;
   logic        intr;
   logic        int_ack;

   modport master (
      output en, we, addr, din, int_ack,
      input  dout, intr
   );

   modport slave (
      input  en, we, addr, din, int_ack,
      output dout, intr
   );
endinterface

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt responder: edge-captured pending bits, mask, int/int_ack FSM.
// Optional build macro INTC_VECTOR_EN adds a read-only fixed-priority VECTOR register at offset 2.
module interrupt_controller #(
   parameter int unsigned NUM_SRC = 31
) (
   input  logic                  clk,
   input  logic                  rst,
   interrupt_controller_if.slave bus,
   input  logic [NUM_SRC-1:0]    irq
);

   localparam int unsigned REG_W    = 32;
   localparam logic [63:0] SRC_ONES = (64'd1 << NUM_SRC) - 64'd1;
   localparam logic [REG_W-1:0] SRC_BITS  = REG_W'(SRC_ONES << 1);
   localparam logic [REG_W-1:0] MASK_BITS = SRC_BITS | REG_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [REG_W-1:0]   mask_q, mask_d;
   logic [REG_W-1:0]   status_q, status_d;
   logic [NUM_SRC-1:0] irq_q, irq_d;
   logic               int_q, int_d;

   logic               wr_mask, wr_status, req;
   logic [REG_W-1:0]   hw_set;
   logic [REG_W-1:0]   rd_data;
   logic               unused_addr;

   assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         mask_q   <= '0;
         status_q <= '0;
         irq_q    <= '0;
         int_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         status_q <= status_d;
         irq_q    <= irq_d;
         int_q    <= int_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      status_d  = status_q;
      irq_d     = irq;
      wr_mask   = bus.en & bus.we & (bus.addr[3:2] == 2'd0);
      wr_status = bus.en & bus.we & (bus.addr[3:2] == 2'd1);
      req       = mask_q[0] & (|(status_q & mask_q & SRC_BITS));
      hw_set    = REG_W'({irq & ~irq_q, 1'b0});

      if (wr_mask)   mask_d   = bus.din & MASK_BITS;
      if (wr_status) status_d = status_q & ~(bus.din & SRC_BITS);
      // Hardware set is applied after W1C so a colliding edge is never lost.
      status_d = status_d | hw_set;

      case (state_q)
         ST_IDLE: begin
            if (req) state_d = ST_ASSERT;
         end
         ST_ASSERT: begin
            // Ack clears GIE after any same-cycle software MASK write.
            if (bus.int_ack) begin
               state_d   = ST_SERVICE;
               mask_d[0] = 1'b0;
            end else if (!req) begin
               state_d = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (mask_q[0]) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      int_d = (state_d == ST_ASSERT);
   end

   // Combinational read mux; VECTOR is the lowest pending-and-enabled bit position.
   always_comb begin
      rd_data = '0;
      case (bus.addr[3:2])
         2'd0: rd_data = mask_q;
         2'd1: rd_data = status_q;
`ifdef INTC_VECTOR_EN
         2'd2: begin
            for (int i = NUM_SRC; i >= 1; i--) begin
               if (status_q[i] & mask_q[i]) rd_data = REG_W'(i);
            end
         end
`else
         2'd2: rd_data = '0;
`endif
         default: rd_data = '0;
      endcase
      bus.dout = bus.en ? rd_data : '0;
   end

   assign bus.intr = int_q;

endmodule
